// File: rtl/aes_comp_key_mem_pkg.sv
// Shared constants, encodings and GF(2^8) helpers for the AES round-key memory.
// Build option: AES_KEY_MEM_256_EN enables the 15-entry AES-128/AES-256 configuration.
package aes_comp_key_mem_pkg;

  localparam logic [3:0] AES128_ROUNDS = 4'ha;
  localparam logic [3:0] AES256_ROUNDS = 4'he;

`ifdef AES_KEY_MEM_256_EN
  localparam int MEM_DEPTH = 15;
  localparam int KEY_W     = 256;
`else
  localparam int MEM_DEPTH = 11;
  localparam int KEY_W     = 128;
`endif

  typedef enum logic {
    KEYLEN_128 = 1'b0,
    KEYLEN_256 = 1'b1
  } keylen_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_INIT     = 2'd1,
    ST_GENERATE = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  function automatic logic [7:0] gm2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        acc = acc ^ sh;
      end else begin
        acc = acc;
      end
      sh = gm2(sh);
    end
    return acc;
  endfunction

  // x^254 == x^-1 in GF(2^8), and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_comp_sbox4.sv
// Combinational forward AES S-box applied to all four bytes of a 32-bit word.
module aes_comp_sbox4
  import aes_comp_key_mem_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    logic [7:0] v;
    v = gf_inv(b);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  // Byte-wise substitution.
  always_comb begin
    word_o = 32'h0;
    for (int i = 0; i < 4; i++) begin
      word_o[8*i +: 8] = sbox_fwd(word_i[8*i +: 8]);
    end
  end

endmodule

// File: rtl/aes_comp_key_mem.sv
// AES round-key expansion and storage: one round key generated per cycle, read back by index.
// Build option: AES_KEY_MEM_256_EN adds AES-256 support and a 15-entry memory.
module aes_comp_key_mem
  import aes_comp_key_mem_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         init,
  input  logic [255:0] key,
  input  logic         keylen,
  input  logic [3:0]   round,
  output logic [127:0] round_key,
  output logic         ready
);

  state_e             state_q, state_d;
  logic               ready_q, ready_d;
  logic [3:0]         round_ctr_q, round_ctr_d;
  logic [7:0]         rcon_q, rcon_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [127:0]       prev1_q;
  logic [127:0]       mem_q [MEM_DEPTH];

  logic               is256_s;
  logic               odd_s;
  logic               we_s;
  logic               rcon_adv_s;
  logic [3:0]         max_round_s;
  logic [127:0]       base_s;
  logic [127:0]       new_key_s;
  logic [31:0]        sub_in_s;
  logic [31:0]        sub_out_s;
  logic [31:0]        temp_s;
  logic [31:0]        w0_s, w1_s, w2_s, w3_s;

`ifdef AES_KEY_MEM_256_EN
  keylen_e            keylen_q, keylen_d;
  logic [127:0]       prev2_q;

  assign is256_s = (keylen_q == KEYLEN_256);
`else
  logic               unused_cfg_s;

  assign is256_s      = 1'b0;
  assign unused_cfg_s = ^{keylen, key[127:0]};
`endif

  assign max_round_s = is256_s ? AES256_ROUNDS : AES128_ROUNDS;
  assign ready       = ready_q;

  // FSM next state and control.
  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    round_ctr_d = round_ctr_q;
    rcon_d      = rcon_q;
    key_d       = key_q;
    we_s        = 1'b0;
`ifdef AES_KEY_MEM_256_EN
    keylen_d    = keylen_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (init) begin
          key_d   = key[255 -: KEY_W];
          ready_d = 1'b0;
          state_d = ST_INIT;
`ifdef AES_KEY_MEM_256_EN
          keylen_d = keylen_e'(keylen);
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_INIT: begin
        round_ctr_d = 4'd0;
        rcon_d      = 8'h01;
        state_d     = ST_GENERATE;
      end
      ST_GENERATE: begin
        we_s        = 1'b1;
        round_ctr_d = round_ctr_q + 4'd1;
        if (rcon_adv_s) begin
          rcon_d = gm2(rcon_q);
        end else begin
          rcon_d = rcon_q;
        end
        if (round_ctr_q == max_round_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_GENERATE;
        end
      end
      ST_DONE: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // AES-256 odd keys skip RotWord and rcon, and derive from the key two steps back.
  always_comb begin
    base_s = prev1_q;
    odd_s  = 1'b0;
`ifdef AES_KEY_MEM_256_EN
    if (is256_s) begin
      base_s = prev2_q;
      odd_s  = round_ctr_q[0];
    end else begin
      base_s = prev1_q;
      odd_s  = 1'b0;
    end
`endif
    sub_in_s   = odd_s ? prev1_q[31:0] : {prev1_q[23:0], prev1_q[31:24]};
    rcon_adv_s = (round_ctr_q != 4'd0) && !odd_s;
  end

  aes_comp_sbox4 u_sbox (
    .word_i (sub_in_s),
    .word_o (sub_out_s)
  );

  // Next round key: raw key halves first, then derived words.
  always_comb begin
    temp_s = sub_out_s ^ (odd_s ? 32'h0 : {rcon_q, 24'h000000});
    w0_s   = base_s[127:96] ^ temp_s;
    w1_s   = base_s[95:64]  ^ w0_s;
    w2_s   = base_s[63:32]  ^ w1_s;
    w3_s   = base_s[31:0]   ^ w2_s;
    if (round_ctr_q == 4'd0) begin
      new_key_s = key_q[KEY_W-1 -: 128];
    end else if (is256_s && (round_ctr_q == 4'd1)) begin
      new_key_s = key_q[127:0];
    end else begin
      new_key_s = {w0_s, w1_s, w2_s, w3_s};
    end
  end

  // Control and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      round_ctr_q <= 4'd0;
      rcon_q      <= 8'h00;
      key_q       <= '0;
      prev1_q     <= 128'h0;
`ifdef AES_KEY_MEM_256_EN
      keylen_q    <= KEYLEN_128;
      prev2_q     <= 128'h0;
`endif
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      round_ctr_q <= round_ctr_d;
      rcon_q      <= rcon_d;
      key_q       <= key_d;
`ifdef AES_KEY_MEM_256_EN
      keylen_q    <= keylen_d;
`endif
      if (we_s) begin
        prev1_q <= new_key_s;
`ifdef AES_KEY_MEM_256_EN
        prev2_q <= prev1_q;
`endif
      end else begin
        prev1_q <= prev1_q;
      end
    end
  end

  // Round-key storage; cleared by reset so an aborted expansion leaves nothing behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= 128'h0;
      end
    end else if (we_s) begin
      mem_q[round_ctr_q] <= new_key_s;
    end else begin
      mem_q[0] <= mem_q[0];
    end
  end

  // Read port: indexes past the last round of the active key length read as zero.
  always_comb begin
    if (round <= max_round_s) begin
      round_key = mem_q[round];
    end else begin
      round_key = 128'h0;
    end
  end

endmodule

// File: tb/tb_aes_comp_key_mem.sv
// Self-checking bench for aes_comp_key_mem using FIPS-197 key-expansion vectors.
module tb_aes_comp_key_mem;

  logic         clk;
  logic         reset;
  logic         init;
  logic [255:0] key;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic         ready;

  int checks   = 0;
  int failures = 0;

  string        tag_q[$];
  logic [127:0] exp_q[$];

  localparam logic [255:0] KEY_A   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_B   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY_256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] A_R1    = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] A_R10   = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] B_R1    = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] B_R2    = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] B_R10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  aes_comp_key_mem dut (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
    .key       (key),
    .keylen    (keylen),
    .round     (round),
    .round_key (round_key),
    .ready     (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_key(input logic [3:0] r, input logic [127:0] exp, input string tag);
    string        t;
    logic [127:0] e;
    @(negedge clk);
    round = r;
    tag_q.push_back(tag);
    exp_q.push_back(exp);
    #2;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    check_eq(t, round_key, e);
  endtask

  // Counts rising edges from the one that samples init up to ready high.
  task automatic expand(input logic [255:0] k, input logic kl, input int exp_lat, input string tag,
                        input int pulse_at, input logic [255:0] pulse_key);
    int n;
    n = 0;
    @(negedge clk);
    key    = k;
    keylen = kl;
    init   = 1'b1;
    do begin
      @(posedge clk);
      n++;
      #1;
      init = (n == pulse_at);
      if (n == pulse_at) begin
        key    = pulse_key;
        keylen = ~kl;
      end
    end while (!ready && n < 40);
    init = 1'b0;
    check_eq(tag, 128'(n), 128'(exp_lat));
  endtask

  initial begin
    int n;
    reset  = 1'b1;
    init   = 1'b0;
    key    = '0;
    keylen = 1'b0;
    round  = 4'd0;
    #3;
    check_eq("reset_ready", 128'(ready), 128'h1);
    check_eq("reset_round_key", round_key, 128'h0);
    @(negedge clk);
    reset = 1'b0;

    expand(KEY_A, 1'b0, 14, "a_latency", 0, '0);
    expect_key(4'd0, KEY_A[255:128], "a_r0");
    expect_key(4'd1, A_R1, "a_r1");
    expect_key(4'd10, A_R10, "a_r10");
    expect_key(4'd11, 128'h0, "a_r11_zero");
    expect_key(4'd15, 128'h0, "a_r15_zero");

    expand(KEY_B, 1'b0, 14, "b_latency", 0, '0);
    expect_key(4'd1, B_R1, "b_r1");
    expect_key(4'd2, B_R2, "b_r2");
    expect_key(4'd10, B_R10, "b_r10");
    expect_key(4'd11, 128'h0, "b_r11_zero");

    expand(KEY_A, 1'b0, 14, "pulse_latency", 6, KEY_B);
    expect_key(4'd0, KEY_A[255:128], "pulse_r0");
    expect_key(4'd10, A_R10, "pulse_r10");

    round = 4'd0;
    @(negedge clk);
    key    = KEY_B;
    keylen = 1'b0;
    init   = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_eq("midgen_reset_ready", 128'(ready), 128'h1);
    check_eq("midgen_reset_key", round_key, 128'h0);
    @(negedge clk);
    reset = 1'b0;
    expect_key(4'd0, 128'h0, "no_partial_r0");
    expect_key(4'd3, 128'h0, "no_partial_r3");
    expand(KEY_A, 1'b0, 14, "post_reset_latency", 0, '0);
    expect_key(4'd10, A_R10, "post_reset_r10");

    @(negedge clk);
    key    = KEY_B;
    keylen = 1'b0;
    init   = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!ready && n < 40);
    check_eq("held_first_latency", 128'(n), 128'd14);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!(ready && n > 1) && n < 40);
    init = 1'b0;
    check_eq("held_restart_latency", 128'(n), 128'd14);
    expect_key(4'd10, B_R10, "held_r10");

`ifdef AES_KEY_MEM_256_EN
    expand(KEY_256, 1'b1, 18, "k256_latency", 0, '0);
    expect_key(4'd0, KEY_256[255:128], "k256_r0");
    expect_key(4'd1, KEY_256[127:0], "k256_r1");
    expect_key(4'd2, 128'ha573c29fa176c498a97fce93a572c09c, "k256_r2");
    expect_key(4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36, "k256_r14");
    expect_key(4'd15, 128'h0, "k256_r15_zero");
    expand(KEY_A, 1'b0, 14, "back128_latency", 0, '0);
    expect_key(4'd10, A_R10, "back128_r10");
    expect_key(4'd11, 128'h0, "back128_r11_zero");
    expect_key(4'd14, 128'h0, "back128_r14_zero");
`else
    expand({KEY_A[255:128], 128'hdeadbeefcafef00d0123456789abcdef}, 1'b1, 14, "kl1_latency", 0, '0);
    expect_key(4'd0, KEY_A[255:128], "kl1_r0");
    expect_key(4'd10, A_R10, "kl1_r10");
    expect_key(4'd14, 128'h0, "kl1_r14_zero");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/aes_comp_key_mem.md
AES_COMP_KEY_MEM -- requirements
Module: aes_comp_key_mem

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: sole clock, all state on rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port init, input, 1 bit: start key expansion, sampled only in IDLE.
REQ-004 The block SHALL have port key, input, 256 bits: cipher key; a 128-bit key occupies key[255:128].
REQ-005 The block SHALL have port keylen, input, 1 bit: 0 = AES-128, 1 = AES-256; sampled with init.
REQ-006 The block SHALL have port round, input, 4 bits: round-key index driven by the decipher round block.
REQ-007 The block SHALL have port round_key, output, 128 bits: stored round key selected by round.
REQ-008 The block SHALL have port ready, output, 1 bit: 1 = all round keys valid and block idle.

Function
REQ-009 The block SHALL implement states IDLE, INIT and GENERATE, plus DONE.
REQ-010 In IDLE with init=1, the block SHALL latch key and keylen, drive ready to 0 on the next edge, and enter INIT.
REQ-011 In INIT, the block SHALL clear the internal round counter to 0, set rcon to 8'h01, then enter GENERATE.
REQ-012 In GENERATE, the block SHALL write exactly one 128-bit round key per cycle into key memory entry round_ctr, then increment round_ctr.
REQ-013 Key expansion SHALL follow FIPS-197: RotWord, SubWord, rcon XOR on the first word of each new 128-bit key (AES-128) or of each even key (AES-256); SubWord only on odd AES-256 keys.
REQ-014 For AES-256, entries 0 and 1 SHALL be key[255:128] and key[127:0] respectively.
REQ-015 rcon SHALL advance by GF(2^8) doubling with reduction polynomial 8'h1b only after it is consumed: 01,02,04,...,80,1b,36.
REQ-016 GENERATE SHALL last 11 cycles (AES-128) or 15 cycles (AES-256), then enter DONE.
REQ-017 In DONE, the block SHALL set ready to 1 and enter IDLE.
REQ-018 From init sampled to ready high SHALL take exactly 14 cycles for AES-128 and 18 cycles for AES-256.
REQ-019 round_key SHALL be combinational from round and the memory, with no added latency.
REQ-020 round_key SHALL be 128'h0 when round exceeds 10 (AES-128) or 14 (AES-256).
REQ-021 While ready=0, round_key contents SHALL be undefined for unwritten entries; consumers SHALL NOT rely on them.
REQ-022 The block SHALL ignore init outside IDLE; key and keylen changes while busy SHALL have no effect.
REQ-023 init held high continuously SHALL restart expansion on each return to IDLE, identically each time.

Reset
REQ-024 Reset SHALL force IDLE, ready=1, round_ctr=0, rcon=8'h00, all memory entries 0, and round_key=0, independent of clk.
REQ-025 Reset mid-GENERATE SHALL abort immediately; after release, no partial keys SHALL remain.

Configuration
REQ-026 With AES_KEY_MEM_256_EN defined, the block SHALL support both key lengths with a 15-entry memory.
REQ-027 Without AES_KEY_MEM_256_EN, the block SHALL implement an 11-entry memory and AES-128 only.
REQ-028 Without AES_KEY_MEM_256_EN, the block SHALL ignore keylen and key[127:0] entirely, and 14-cycle latency SHALL apply.

Structure
REQ-029 A shared package SHALL hold: AES128_ROUNDS=4'ha, AES256_ROUNDS=4'he, keylen encodings, FSM state encodings, and the gm2 doubling function.
REQ-030 SubWord SHALL be an instance of sub-module aes_comp_sbox4 (combinational forward 4-byte S-box); there SHALL be one instance only.

Verification
REQ-031 Bench: AES-128 key 000102030405060708090a0b0c0d0e0f, init -> ready after 14 cycles; round=10 gives 13111d7fe3944a17f307a78b4d2b30c5; round=0 gives the key.
REQ-032 Bench: AES-128 key 2b7e151628aed2a6abf7158809cf4f3c -> round=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; round=11 gives 0.
REQ-033 Bench (macro defined): AES-256 key 000102...1f, keylen=1 -> ready after 18 cycles; round=14 gives 24fc79ccbf0979e9371ac23c6d68de36.
REQ-034 Bench: init re-pulsed at cycle 5 of GENERATE with a new key -> ignored; final keys match the first key.
REQ-035 Bench: reset asserted at cycle 7 of GENERATE -> ready=1 and round_key=0 asynchronously; a fresh init then yields correct keys.
REQ-036 Bench (macro undefined): keylen=1 with a 128-bit key vector -> results identical to REQ-031, and latency of 14 cycles.
